// File: rtl/biriscv_exec_writeback.sv
// Exec-to-writeback retirement stage for the biriscv pipeline.
// Issued instructions travel down a LATENCY-deep tag pipeline of
// {valid, rd, pc}. The oldest tag is paired with exec_value_i and lands in a
// single write register that drives the register-file write port. The block
// also provides a pending-write scoreboard and a retirement counter.
// Optional feature: define BIRISCV_WB_BYPASS_EN to forward the write-register
// value to two operand queries. When it is undefined the bypass outputs are
// tied to zero.
module biriscv_exec_writeback #(
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        issue_valid_i,
  input  logic        hold_i,
  input  logic [4:0]  issue_rd_idx_i,
  input  logic [31:0] issue_pc_i,
  input  logic        flush_i,
  input  logic [31:0] exec_value_i,
  input  logic [4:0]  query_ra_idx_i,
  input  logic [4:0]  query_rb_idx_i,
  output logic        rf_wr_en_o,
  output logic [4:0]  rf_wr_idx_o,
  output logic [31:0] rf_wr_value_o,
  output logic [31:0] rf_wr_pc_o,
  output logic [31:0] pending_o,
  output logic [31:0] retire_count_o,
  output logic        bypass_ra_hit_o,
  output logic        bypass_rb_hit_o,
  output logic [31:0] bypass_ra_value_o,
  output logic [31:0] bypass_rb_value_o
);

  localparam int DATA_W = 32;

  logic              w_accept;
  logic              w_capture;
  logic              r_tag_vld [LATENCY];
  logic [4:0]        r_tag_rd  [LATENCY];
  logic [31:0]       r_tag_pc  [LATENCY];
  logic              r_wb_vld;
  logic              r_wr_en;
  logic [4:0]        r_wr_idx;
  logic [DATA_W-1:0] r_wr_value;
  logic [31:0]       r_wr_pc;
  logic [31:0]       r_retire_cnt;
  logic [31:0]       w_pending;

  assign w_accept  = issue_valid_i & ~hold_i & ~flush_i;
  // Oldest tag is retired unless a flush kills it in the same cycle.
  assign w_capture = r_tag_vld[LATENCY-1] & ~flush_i;

  // Tag valid pipeline: advances every cycle, flush clears every stage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < LATENCY; s++) r_tag_vld[s] <= 1'b0;
    end else if (flush_i) begin
      for (int s = 0; s < LATENCY; s++) r_tag_vld[s] <= 1'b0;
    end else begin
      r_tag_vld[0] <= w_accept;
      for (int s = 1; s < LATENCY; s++) r_tag_vld[s] <= r_tag_vld[s-1];
    end
  end

  // Tag payload pipeline: rd/pc follow the valids; meaningless when invalid.
  always_ff @(posedge clk_i) begin
    r_tag_rd[0] <= issue_rd_idx_i;
    r_tag_pc[0] <= issue_pc_i;
    for (int s = 1; s < LATENCY; s++) begin
      r_tag_rd[s] <= r_tag_rd[s-1];
      r_tag_pc[s] <= r_tag_pc[s-1];
    end
  end

  // Write register: pairs the oldest tag with the exec result, counts retirements.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wb_vld     <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_idx     <= '0;
      r_wr_value   <= '0;
      r_wr_pc      <= '0;
      r_retire_cnt <= '0;
    end else begin
      r_wb_vld <= w_capture;
      // x0 retires silently: the strobe stays low but the payload still updates.
      r_wr_en  <= w_capture & (r_tag_rd[LATENCY-1] != 5'd0);
      if (w_capture) begin
        r_wr_idx     <= r_tag_rd[LATENCY-1];
        r_wr_value   <= exec_value_i;
        r_wr_pc      <= r_tag_pc[LATENCY-1];
        r_retire_cnt <= r_retire_cnt + 32'd1;
      end
    end
  end

  // Scoreboard of in-flight destinations; the current-cycle issue is not included.
  always_comb begin
    w_pending = '0;
    for (int s = 0; s < LATENCY; s++) begin
      if (r_tag_vld[s]) w_pending[r_tag_rd[s]] = 1'b1;
    end
    if (r_wb_vld) w_pending[r_wr_idx] = 1'b1;
    w_pending[0] = 1'b0;
  end

  assign rf_wr_en_o     = r_wr_en;
  assign rf_wr_idx_o    = r_wr_idx;
  assign rf_wr_value_o  = r_wr_value;
  assign rf_wr_pc_o     = r_wr_pc;
  assign pending_o      = w_pending;
  assign retire_count_o = r_retire_cnt;

`ifdef BIRISCV_WB_BYPASS_EN
  logic w_ra_hit;
  logic w_rb_hit;

  assign w_ra_hit          = r_wr_en & (query_ra_idx_i == r_wr_idx) & (query_ra_idx_i != 5'd0);
  assign w_rb_hit          = r_wr_en & (query_rb_idx_i == r_wr_idx) & (query_rb_idx_i != 5'd0);
  assign bypass_ra_hit_o   = w_ra_hit;
  assign bypass_rb_hit_o   = w_rb_hit;
  assign bypass_ra_value_o = w_ra_hit ? r_wr_value : '0;
  assign bypass_rb_value_o = w_rb_hit ? r_wr_value : '0;
`else
  // Query indices have no consumer without forwarding.
  logic w_unused_query;

  assign w_unused_query    = ^{query_ra_idx_i, query_rb_idx_i};
  assign bypass_ra_hit_o   = 1'b0;
  assign bypass_rb_hit_o   = 1'b0;
  assign bypass_ra_value_o = '0;
  assign bypass_rb_value_o = '0;
`endif

endmodule

// File: tb/tb_biriscv_exec_writeback.sv
// Scoreboard bench for biriscv_exec_writeback: accepted issues push their
// expected retirement onto a queue, the monitor pops and compares each cycle.
module tb_biriscv_exec_writeback;

  localparam int LAT = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        issue_valid_i;
  logic        hold_i;
  logic [4:0]  issue_rd_idx_i;
  logic [31:0] issue_pc_i;
  logic        flush_i;
  logic [31:0] exec_value_i;
  logic [4:0]  query_ra_idx_i;
  logic [4:0]  query_rb_idx_i;
  logic        rf_wr_en_o;
  logic [4:0]  rf_wr_idx_o;
  logic [31:0] rf_wr_value_o;
  logic [31:0] rf_wr_pc_o;
  logic [31:0] pending_o;
  logic [31:0] retire_count_o;
  logic        bypass_ra_hit_o;
  logic        bypass_rb_hit_o;
  logic [31:0] bypass_ra_value_o;
  logic [31:0] bypass_rb_value_o;

  biriscv_exec_writeback #(.LATENCY(LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .hold_i(hold_i),
    .issue_rd_idx_i(issue_rd_idx_i), .issue_pc_i(issue_pc_i),
    .flush_i(flush_i), .exec_value_i(exec_value_i),
    .query_ra_idx_i(query_ra_idx_i), .query_rb_idx_i(query_rb_idx_i),
    .rf_wr_en_o(rf_wr_en_o), .rf_wr_idx_o(rf_wr_idx_o),
    .rf_wr_value_o(rf_wr_value_o), .rf_wr_pc_o(rf_wr_pc_o),
    .pending_o(pending_o), .retire_count_o(retire_count_o),
    .bypass_ra_hit_o(bypass_ra_hit_o), .bypass_rb_hit_o(bypass_rb_hit_o),
    .bypass_ra_value_o(bypass_ra_value_o), .bypass_rb_value_o(bypass_rb_value_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] val;
    int          due;
  } ent_t;

  ent_t        sb[$];
  logic [31:0] ovr [int];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] exp_cnt = 0;
  logic [4:0]  last_idx = 0;
  logic [31:0] last_val = 0;
  logic [31:0] last_pc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] xval(input int c);
    logic [31:0] cc;
    cc = 32'(c);
    if (ovr.exists(c)) return ovr[c];
    return (cc * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  task automatic chk_zero(input string tg);
    chk({tg, "_wr_en"}, 32'(rf_wr_en_o), 32'd0);
    chk({tg, "_wr_idx"}, 32'(rf_wr_idx_o), 32'd0);
    chk({tg, "_wr_value"}, rf_wr_value_o, 32'd0);
    chk({tg, "_wr_pc"}, rf_wr_pc_o, 32'd0);
    chk({tg, "_pending"}, pending_o, 32'd0);
    chk({tg, "_retire_cnt"}, retire_count_o, 32'd0);
    chk({tg, "_ra_hit"}, 32'(bypass_ra_hit_o), 32'd0);
    chk({tg, "_rb_hit"}, 32'(bypass_rb_hit_o), 32'd0);
    chk({tg, "_ra_value"}, bypass_ra_value_o, 32'd0);
    chk({tg, "_rb_value"}, bypass_rb_value_o, 32'd0);
  endtask

  // One clock cycle: drive at #1 after the edge, check on the falling edge.
  task automatic step(input logic v, input logic h, input logic f, input logic [4:0] rd,
                      input logic [31:0] pc, input logic [4:0] qa, input logic [4:0] qb);
    logic        exp_en;
    logic        exp_ha;
    logic        exp_hb;
    logic [31:0] exp_pend;
    ent_t        e;
    issue_valid_i  = v;
    hold_i         = h;
    flush_i        = f;
    issue_rd_idx_i = rd;
    issue_pc_i     = pc;
    query_ra_idx_i = qa;
    query_rb_idx_i = qb;
    exec_value_i   = xval(cyc);
    @(negedge clk_i);
    exp_en   = 1'b0;
    exp_pend = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e        = sb.pop_front();
      exp_cnt  = exp_cnt + 32'd1;
      exp_en   = (e.rd != 5'd0);
      last_idx = e.rd;
      last_val = e.val;
      last_pc  = e.pc;
      exp_pend[e.rd] = 1'b1;
    end
    foreach (sb[i]) if (sb[i].due - LAT <= cyc) exp_pend[sb[i].rd] = 1'b1;
    exp_pend[0] = 1'b0;
    chk("wr_en", 32'(rf_wr_en_o), 32'(exp_en));
    chk("wr_idx", 32'(rf_wr_idx_o), 32'(last_idx));
    chk("wr_value", rf_wr_value_o, last_val);
    chk("wr_pc", rf_wr_pc_o, last_pc);
    chk("retire_cnt", retire_count_o, exp_cnt);
    chk("pending", pending_o, exp_pend);
`ifdef BIRISCV_WB_BYPASS_EN
    exp_ha = exp_en && (qa == last_idx) && (qa != 5'd0);
    exp_hb = exp_en && (qb == last_idx) && (qb != 5'd0);
`else
    exp_ha = 1'b0;
    exp_hb = 1'b0;
`endif
    chk("ra_hit", 32'(bypass_ra_hit_o), 32'(exp_ha));
    chk("rb_hit", 32'(bypass_rb_hit_o), 32'(exp_hb));
    chk("ra_value", bypass_ra_value_o, exp_ha ? last_val : 32'd0);
    chk("rb_value", bypass_rb_value_o, exp_hb ? last_val : 32'd0);
    if (f) sb.delete();
    if (v && !h && !f) begin
      e.rd  = rd;
      e.pc  = pc;
      e.val = xval(cyc + LAT);
      e.due = cyc + LAT + 1;
      sb.push_back(e);
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input logic [4:0] qa, input logic [4:0] qb);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, qa, qb);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1;
    issue_valid_i = 1'b0; hold_i = 1'b0; flush_i = 1'b0;
    issue_rd_idx_i = '0; issue_pc_i = '0; exec_value_i = '0;
    query_ra_idx_i = '0; query_rb_idx_i = '0;
    #12;
    chk_zero("reset");
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    cyc = 0;

    // Basic write of 0xDEADBEEF to x5
    ovr[cyc + LAT] = 32'hDEADBEEF;
    step(1'b1, 1'b0, 1'b0, 5'd5, 32'h100, 5'd5, 5'd0);
    idle(4, 5'd5, 5'd0);
    // x0 retires without a write strobe
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'h104, 5'd0, 5'd0);
    idle(4, 5'd0, 5'd0);
    // Flush one cycle after issue
    step(1'b1, 1'b0, 1'b0, 5'd7, 32'h108, 5'd7, 5'd7);
    step(1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 5'd7, 5'd7);
    idle(4, 5'd7, 5'd7);
    // Hold rejects the second issue, then it is re-presented
    step(1'b1, 1'b0, 1'b0, 5'd3, 32'h200, 5'd3, 5'd4);
    step(1'b1, 1'b1, 1'b0, 5'd4, 32'h204, 5'd3, 5'd4);
    step(1'b1, 1'b0, 1'b0, 5'd4, 32'h204, 5'd3, 5'd4);
    idle(4, 5'd3, 5'd4);
    // Back-to-back without hold
    step(1'b1, 1'b0, 1'b0, 5'd3, 32'h300, 5'd3, 5'd4);
    step(1'b1, 1'b0, 1'b0, 5'd4, 32'h304, 5'd3, 5'd4);
    idle(4, 5'd3, 5'd4);
    // Forwarding of x9
    ovr[cyc + LAT] = 32'h00001234;
    step(1'b1, 1'b0, 1'b0, 5'd9, 32'h400, 5'd9, 5'd0);
    idle(4, 5'd9, 5'd0);
    // Flush while one instruction sits in the write register; flush beats valid
    step(1'b1, 1'b0, 1'b0, 5'd20, 32'h500, 5'd20, 5'd21);
    step(1'b1, 1'b0, 1'b0, 5'd21, 32'h504, 5'd20, 5'd21);
    step(1'b1, 1'b0, 1'b0, 5'd22, 32'h508, 5'd20, 5'd21);
    step(1'b1, 1'b0, 1'b1, 5'd23, 32'h50C, 5'd20, 5'd21);
    idle(4, 5'd20, 5'd21);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] qa;
      logic [4:0] qb;
      qa = ($urandom_range(0, 1) == 1) ? last_idx : 5'($urandom_range(0, 31));
      qb = ($urandom_range(0, 1) == 1) ? last_idx : 5'($urandom_range(0, 31));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0,
           5'($urandom_range(0, 31)), $urandom, qa, qb);
    end
    idle(4, 5'd0, 5'd0);

    // Retirement counter wrap
    force dut.r_retire_cnt = 32'hFFFFFFFF;
    #1;
    release dut.r_retire_cnt;
    exp_cnt = 32'hFFFFFFFF;
    idle(1, 5'd0, 5'd0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'h600, 5'd0, 5'd0);
    idle(4, 5'd0, 5'd0);
    chk("wrap_cnt", retire_count_o, 32'd0);

    // Reset in the middle of traffic
    step(1'b1, 1'b0, 1'b0, 5'd11, 32'h700, 5'd11, 5'd12);
    step(1'b1, 1'b0, 1'b0, 5'd12, 32'h704, 5'd11, 5'd12);
    step(1'b1, 1'b0, 1'b0, 5'd13, 32'h708, 5'd11, 5'd12);
    issue_valid_i = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    chk_zero("midrst");
    sb.delete();
    exp_cnt  = 0;
    last_idx = 0;
    last_val = 0;
    last_pc  = 0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    cyc = cyc + 2;
    idle(6, 5'd11, 5'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
